fetch_queue: RTL and testbench

Instruction-fetch buffer sitting directly downstream of the program counter / PC+4 adder pair in the mips32 pipeline. Takes the current PC, issues one instruction-memory read at a time, and queues returned instructions with their PC for the decode stage. Drives the ProgramCounter `stall` input so the PC advances only when a fetch is actually issued. Supports branch flush with discard of an in-flight memory response.

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction fetch buffer between the PC and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  pc_in,
  input  logic                         flush,
  output logic                         fetch_stall,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [31:0]                  id_instr,
  output logic [31:0]                  id_pc,
  output logic [31:0]                  id_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_pending_pc;
  logic [31:0]      r_mem_pc    [DEPTH];
  logic [31:0]      r_mem_instr [DEPTH];

  logic             w_req;
  logic             w_ack_wait;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  assign w_empty    = (r_count == '0);
  assign w_ack_wait = (r_state == S_WAIT) && imem_ack;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_ack_wait && w_empty && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed word that decode takes immediately never occupies a slot.
  assign w_push = w_ack_wait && !flush && !(w_byp && id_ready);
  assign w_pop  = !w_empty && id_ready && !flush;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and request; credit ignores a same-cycle pop so a push never overflows.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = !flush && (r_count < CW'(DEPTH));
        if (w_req) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_req       = !flush && (r_count < CW'(DEPTH - 1));
          w_state_nxt = w_req ? S_WAIT : S_IDLE;
        end else if (flush) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        // The dropped response is the only one outstanding, so its ack always ends DROP.
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req    = w_req;
  assign imem_addr   = pc_in;
  assign fetch_stall = !w_req && !flush;
  assign count       = r_count;

  // Queue storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pending_pc <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else begin
      if (w_req) begin
        r_pending_pc <= pc_in;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem_pc[r_wr_ptr]    <= r_pending_pc;
          r_mem_instr[r_wr_ptr] <= imem_rdata;
          r_wr_ptr              <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Decode-side head view, optionally overridden by the bypass path.
  always_comb begin
    id_valid = !w_empty;
    id_pc    = r_mem_pc[r_rd_ptr];
    id_instr = r_mem_instr[r_rd_ptr];
    if (w_byp) begin
      id_valid = 1'b1;
      id_pc    = r_pending_pc;
      id_instr = imem_rdata;
    end
  end

  assign id_pc_plus4 = id_pc + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC/memory environment, directed cycle checks and an in-order scoreboard.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_in;
  logic          flush;
  logic          fetch_stall;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc_plus4;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [31:0] target = 32'h0;
  int          lat = 1;

  logic        s_req, s_stall, s_flush, s_rst, s_ack;
  logic [31:0] s_addr, s_target;
  int          busy, left;
  logic [31:0] maddr;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, pc ^ 32'hAAAA_0000, pc + 32'd4});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Environment: ProgramCounter model plus a single-outstanding memory with latency `lat`.
  initial begin
    pc_in      = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    busy       = 0;
    left       = 0;
    maddr      = 32'h0;
    forever begin
      @(negedge clk);
      s_req    = imem_req;
      s_addr   = imem_addr;
      s_stall  = fetch_stall;
      s_flush  = flush;
      s_rst    = reset;
      s_ack    = imem_ack;
      s_target = target;
      @(posedge clk);
      #2;
      if (s_rst)        pc_in = 32'h0;
      else if (s_flush) pc_in = s_target;
      else if (!s_stall) pc_in = pc_in + 32'd4;
      if (s_ack) busy = 0;
      if (s_req && !s_rst) begin
        busy  = 1;
        maddr = s_addr;
        left  = lat;
      end
      imem_ack = 1'b0;
      if (busy != 0) begin
        left--;
        if (left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = maddr ^ 32'hAAAA_0000;
        end
      end
    end
  end

  // Monitor: every accepted head entry must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && id_valid && id_ready) begin
        n_vec++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got pc %h instr %h, want no entry", id_pc, id_instr);
        end else begin
          mon_e = exp_q.pop_front();
          if (id_pc !== mon_e.pc || id_instr !== mon_e.instr || id_pc_plus4 !== mon_e.pc4) begin
            n_err++;
            $display("FAIL pop_entry: got pc %h instr %h pc4 %h, want pc %h instr %h pc4 %h",
                     id_pc, id_instr, id_pc_plus4, mon_e.pc, mon_e.instr, mon_e.pc4);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_id_valid",  32'(id_valid),    32'h0);
    chk("rst_id_instr",  id_instr,         32'h0);
    chk("rst_id_pc",     id_pc,            32'h0);
    chk("rst_pc_plus4",  id_pc_plus4,      32'h4);
    chk("rst_imem_req",  32'(imem_req),    32'h1);
    chk("rst_stall",     32'(fetch_stall), 32'h0);
    chk("rst_count",     32'(count),       32'h0);

`ifdef FETCH_QUEUE_BYPASS_EN
    expect_run(32'h20, 8);
    step(); reset = 1'b0; id_ready = 1'b1; flush = 1'b1; target = 32'h20;   // c0
    @(negedge clk);
    chk("byp_flush_req",   32'(imem_req),    32'h0);
    chk("byp_flush_stall", 32'(fetch_stall), 32'h0);
    step(); flush = 1'b0;                                                   // c1
    @(negedge clk);
    chk("byp_req_addr",    imem_addr,        32'h20);
    step();                                                                 // c2
    @(negedge clk);
    chk("byp_valid",       32'(id_valid),    32'h1);
    chk("byp_pc",          id_pc,            32'h20);
    chk("byp_instr",       id_instr,         32'hAAAA_0020);
    chk("byp_count0",      32'(count),       32'h0);
    step();                                                                 // c3
    @(negedge clk);
    chk("byp_count1",      32'(count),       32'h0);
    chk("byp_pc_next",     id_pc,            32'h24);
    repeat (3) step();                                                      // c6
    chk("byp_pop_total",   32'(n_pop),       32'd4);
`else
    expect_run(32'h0, 20);
    step(); reset = 1'b0; id_ready = 1'b1;                                  // c0
    @(negedge clk);
    chk("c0_req",          32'(imem_req),    32'h1);
    chk("c0_addr",         imem_addr,        32'h0);
    step();                                                                 // c1
    @(negedge clk);
    chk("c1_ack_not_yet_valid", 32'(id_valid), 32'h0);
    step();                                                                 // c2
    @(negedge clk);
    chk("c2_valid",        32'(id_valid),    32'h1);
    chk("c2_pc",           id_pc,            32'h0);
    chk("c2_instr",        id_instr,         32'hAAAA_0000);
    step();                                                                 // c3
    @(negedge clk);
    chk("c3_pc",           id_pc,            32'h4);
    chk("c3_instr",        id_instr,         32'hAAAA_0004);
    step(); step(); id_ready = 1'b0;                                        // c5
    repeat (5) step();                                                      // c10
    @(negedge clk);
    chk("full_count",      32'(count),       32'd4);
    chk("full_req",        32'(imem_req),    32'h0);
    chk("full_stall",      32'(fetch_stall), 32'h1);
    chk("full_head_pc",    id_pc,            32'hC);
    step(); id_ready = 1'b1;                                                // c11
    @(negedge clk);
    chk("drain_c11_req",   32'(imem_req),    32'h0);
    step();                                                                 // c12
    @(negedge clk);
    chk("resume_req",      32'(imem_req),    32'h1);
    chk("resume_addr",     imem_addr,        32'h1C);
    chk("resume_count",    32'(count),       32'd3);
    step(); id_ready = 1'b0; flush = 1'b1; target = 32'h10; exp_q.delete(); // c13
    @(negedge clk);
    chk("fack_count",      32'(count),       32'd2);
    chk("fack_head_pc",    id_pc,            32'h14);
    chk("fack_req",        32'(imem_req),    32'h0);
    chk("fack_stall",      32'(fetch_stall), 32'h0);
    step(); flush = 1'b0; lat = 3;                                          // c14
    @(negedge clk);
    chk("fack_next_count", 32'(count),       32'h0);
    chk("fack_next_valid", 32'(id_valid),    32'h0);
    chk("req10",           32'(imem_req),    32'h1);
    chk("req10_addr",      imem_addr,        32'h10);
    step(); flush = 1'b1; target = 32'h40; exp_q.delete(); expect_run(32'h40, 8); // c15
    @(negedge clk);
    chk("fwait_req",       32'(imem_req),    32'h0);
    chk("fwait_stall",     32'(fetch_stall), 32'h0);
    step(); flush = 1'b0;                                                   // c16
    @(negedge clk);
    chk("drop_req",        32'(imem_req),    32'h0);
    chk("drop_stall",      32'(fetch_stall), 32'h1);
    step();                                                                 // c17
    @(negedge clk);
    chk("drop_ack_count",  32'(count),       32'h0);
    chk("drop_ack_req",    32'(imem_req),    32'h0);
    step(); id_ready = 1'b1;                                                // c18
    @(negedge clk);
    chk("redir_req",       32'(imem_req),    32'h1);
    chk("redir_addr",      imem_addr,        32'h40);
    chk("redir_count",     32'(count),       32'h0);
    chk("redir_valid",     32'(id_valid),    32'h0);
    repeat (3) step();                                                      // c21
    @(negedge clk);
    chk("lat3_ack_valid",  32'(id_valid),    32'h0);
    step();                                                                 // c22
    @(negedge clk);
    chk("lat3_valid",      32'(id_valid),    32'h1);
    chk("lat3_pc",         id_pc,            32'h40);
    step(); flush = 1'b1; target = 32'hFFFF_FFF8; lat = 1;                  // c23
    exp_q.delete(); expect_run(32'hFFFF_FFF8, 12);
    step(); flush = 1'b0;                                                   // c24
    repeat (4) step();                                                      // c28
    @(negedge clk);
    chk("wrap_pc",         id_pc,            32'hFFFF_FFFC);
    chk("wrap_instr",      id_instr,         32'h5555_FFFC);
    chk("wrap_pc_plus4",   id_pc_plus4,      32'h0);
    repeat (3) step();                                                      // c31
    chk("pop_total",       32'(n_pop),       32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
